// File: rtl/som_update_sequencer.sv
// ============================================================================
//  Module      : som_update_sequencer
//  Description : Weight-update sequencer for an 8x8 self-organizing map.
//                Latches one winner coordinate per training sample, then
//                sweeps the map column by column. For each column it drives
//                the column index into the neighbourhood-select unit and
//                forwards the returned 16-bit select word to the
//                weight-update datapath over a valid/ready handshake.
//  Options     : SOM_SKIP_FAR_COLS_EN - when defined, only the columns
//                within FAR_DIST of the winner column are swept. When
//                undefined, all eight columns are swept every sample.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module som_update_sequencer #(
    parameter int CNT_W    = 16,
    parameter int FAR_DIST = 2
) (
    input  logic             clk,
    input  logic             rst,
    // winner coordinate from the best-matching-unit search
    input  logic             win_valid,
    output logic             win_ready,
    input  logic [2:0]       win_x,
    input  logic [2:0]       win_y,
    // neighbourhood-select unit
    output logic [2:0]       uss_x_in,
    output logic [2:0]       uss_x_c,
    output logic [2:0]       uss_y_c,
    input  logic [15:0]      uss_sel,
    // weight-update datapath
    output logic             upd_valid,
    input  logic             upd_ready,
    output logic [2:0]       upd_col,
    output logic [15:0]      upd_sel,
    // status
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SWEEP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

`ifdef SOM_SKIP_FAR_COLS_EN
    localparam bit c_skip_en = 1'b1;
`else
    localparam bit c_skip_en = 1'b0;
`endif

    // Window arithmetic is carried at 5 bits so x_c + FAR_DIST cannot wrap.
    localparam logic [4:0] c_far_dist = 5'(FAR_DIST);
    localparam logic [4:0] c_last_col = 5'd7;

    logic [1:0]       r_state;
    logic [2:0]       r_col;
    logic [2:0]       r_x_c;
    logic [2:0]       r_y_c;
    logic [CNT_W-1:0] r_cnt;

    logic [4:0]       w_xc_ext;
    logic [4:0]       w_win_lo;
    logic [4:0]       w_win_hi;
    logic [2:0]       w_start_col;
    logic [2:0]       w_end_col;

    // Column window derived from the latched winner column; the full map is
    // used unless far-column skipping is built in.
    always_comb begin
        w_xc_ext = {2'b00, r_x_c};
        w_win_lo = (w_xc_ext >= c_far_dist) ? (w_xc_ext - c_far_dist) : 5'd0;
        w_win_hi = w_xc_ext + c_far_dist;
        if (w_win_hi > c_last_col) begin
            w_win_hi = c_last_col;
        end
        if (c_skip_en) begin
            w_start_col = 3'(w_win_lo);
            w_end_col   = 3'(w_win_hi);
        end else begin
            w_start_col = 3'd0;
            w_end_col   = 3'd7;
        end
    end

    // Sample sequencing: accept winner, load start column, sweep, report.
    // The end-column test precedes the increment, so r_col never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_col   <= 3'd0;
            r_x_c   <= 3'd0;
            r_y_c   <= 3'd0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (win_valid) begin
                        r_x_c   <= win_x;
                        r_y_c   <= win_y;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_col   <= w_start_col;
                    r_state <= S_SWEEP;
                end
                S_SWEEP: begin
                    if (upd_ready) begin
                        if (r_col == w_end_col) begin
                            r_state <= S_DONE;
                        end else begin
                            r_col <= r_col + 3'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (r_cnt != {CNT_W{1'b1}}) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Status and handshake outputs decode straight from the state register;
    // column and winner coordinates come from registers that hold from LOAD
    // through DONE, so the select word is stable under backpressure.
    assign win_ready  = (r_state == S_IDLE);
    assign upd_valid  = (r_state == S_SWEEP);
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign uss_x_in   = r_col;
    assign uss_x_c    = r_x_c;
    assign uss_y_c    = r_y_c;
    assign upd_col    = r_col;
    assign upd_sel    = uss_sel;
    assign sample_cnt = r_cnt;

endmodule

`default_nettype wire
